// File: rtl/fft_pkg.sv
// Shared constants and helpers for the radix-2^2 SDF FFT datapath stages.
// Q1.15 rounding/saturation bounds are functions of word width so any stage width can reuse them.
package fft_pkg;

  localparam int WIDTH = 16;
  localparam int LOG_N = 6;
  localparam int ADDR_W = 8;

  function automatic longint rndConst(input int w);
    return 64'sd1 <<< (w - 2);
  endfunction

  function automatic longint satMax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint satMin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Quadrant select to twiddle exponent multiplier (bit-reversed order of the radix-2^2 split).
  function automatic logic [1:0] selToK(input logic [1:0] sel);
    case (sel)
      2'd0:    return 2'd0;
      2'd1:    return 2'd2;
      2'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/cmult_q15.sv
// Two-stage pipelined Q1.15 complex multiplier: registered products, then sum/round/saturate
// into the output register. A bypass flag forwards the delayed sample untouched.
module cmult_q15
  import fft_pkg::*;
#(
  parameter int WIDTH = fft_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             bypass_i,
  input  logic [WIDTH-1:0] a_re_i,
  input  logic [WIDTH-1:0] a_im_i,
  input  logic [WIDTH-1:0] b_re_i,
  input  logic [WIDTH-1:0] b_im_i,
  output logic             en_o,
  output logic [WIDTH-1:0] re_o,
  output logic [WIDTH-1:0] im_o
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = 2 * WIDTH + 1;
  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(rndConst(WIDTH));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(satMax(WIDTH));
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(satMin(WIDTH));

  logic signed [PROD_W-1:0] aReX, aImX, bReX, bImX;
  logic signed [PROD_W-1:0] prRR_q, prII_q, prRI_q, prIR_q;
  logic                     en2_q, byp2_q;
  logic [WIDTH-1:0]         dRe2_q, dIm2_q;
  logic signed [SUM_W-1:0]  sumRe, sumIm, shRe, shIm;
  logic [WIDTH-1:0]         re_d, im_d;
  logic                     en_q;
  logic [WIDTH-1:0]         re_q, im_q;

  assign aReX = {{WIDTH{a_re_i[WIDTH-1]}}, a_re_i};
  assign aImX = {{WIDTH{a_im_i[WIDTH-1]}}, a_im_i};
  assign bReX = {{WIDTH{b_re_i[WIDTH-1]}}, b_re_i};
  assign bImX = {{WIDTH{b_im_i[WIDTH-1]}}, b_im_i};

  always_ff @(posedge clock) begin
    if (reset) begin
      en2_q <= 1'b0;
    end else begin
      en2_q <= en_i;
    end
  end

  always_ff @(posedge clock) begin
    if (en_i) begin
      prRR_q <= aReX * bReX;
      prII_q <= aImX * bImX;
      prRI_q <= aReX * bImX;
      prIR_q <= aImX * bReX;
      byp2_q <= bypass_i;
      dRe2_q <= a_re_i;
      dIm2_q <= a_im_i;
    end
  end

  function automatic logic [WIDTH-1:0] satWord(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  // Sums carry one guard bit so the -1*-1 corner cannot wrap before saturation.
  always_comb begin
    sumRe = {prRR_q[PROD_W-1], prRR_q} - {prII_q[PROD_W-1], prII_q};
    sumIm = {prRI_q[PROD_W-1], prRI_q} + {prIR_q[PROD_W-1], prIR_q};
    shRe  = (sumRe + RND) >>> (WIDTH - 1);
    shIm  = (sumIm + RND) >>> (WIDTH - 1);
    re_d  = satWord(shRe);
    im_d  = satWord(shIm);
    if (byp2_q) begin
      re_d = dRe2_q;
      im_d = dIm2_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
    end else begin
      en_q <= en2_q;
      if (en2_q) begin
        re_q <= re_d;
        im_q <= im_d;
      end
    end
  end

  assign en_o = en_q;
  assign re_o = re_q;
  assign im_o = im_q;

endmodule

// File: rtl/twiddle_rotator.sv
// Twiddle-multiply stage of the radix-2^2 SDF FFT: sample counter, twiddle ROM addressing,
// bypass detection and the P1 register that aligns data with the one-cycle ROM read.
module twiddle_rotator
  import fft_pkg::*;
#(
  parameter int WIDTH = fft_pkg::WIDTH,
  parameter int LOG_N = fft_pkg::LOG_N,
  parameter int LOG_M = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic [7:0]       tw_addr,
  input  logic [WIDTH-1:0] tw_re,
  input  logic [WIDTH-1:0] tw_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  logic [LOG_M-1:0] cnt_q, cnt_d;
  logic [1:0]       sel;
  logic [LOG_M-3:0] idx;
  logic [7:0]       addrProd;
  logic             byp;
  logic             en1_q, byp1_q;
  logic [WIDTH-1:0] dRe1_q, dIm1_q;

  assign cnt_d    = cnt_q + 1'b1;
  assign sel      = cnt_q[LOG_M-1:LOG_M-2];
  assign idx      = cnt_q[LOG_M-3:0];
  assign addrProd = 8'(idx) * 8'(selToK(sel));
  assign tw_addr  = addrProd << (LOG_N - LOG_M);
  assign byp      = (tw_addr == 8'd0);

  // M is a power of two, so the natural counter overflow is the block wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      en1_q <= 1'b0;
    end else begin
      en1_q <= di_en;
      if (di_en) begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (di_en) begin
      byp1_q <= byp;
      dRe1_q <= di_re;
      dIm1_q <= di_im;
    end
  end

  cmult_q15 #(
    .WIDTH(WIDTH)
  ) uMult (
    .clock   (clock),
    .reset   (reset),
    .en_i    (en1_q),
    .bypass_i(byp1_q),
    .a_re_i  (dRe1_q),
    .a_im_i  (dIm1_q),
    .b_re_i  (tw_re),
    .b_im_i  (tw_im),
    .en_o    (do_en),
    .re_o    (do_re),
    .im_o    (do_im)
  );

endmodule

// File: tb/tb_twiddle_rotator.sv
// Scoreboard bench for twiddle_rotator: stimulus pushes expected outputs with their issue cycle,
// a monitor pops on every do_en and checks value, 3-cycle latency and hold behaviour.
module tb_twiddle_rotator;

  logic        clock = 1'b0;
  logic        reset;
  logic        di_en;
  logic [15:0] di_re, di_im;
  logic [7:0]  tw_addr;
  logic [15:0] tw_re, tw_im;
  logic        do_en;
  logic [15:0] do_re, do_im;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    int          cyc;
  } exp_t;

  exp_t        sbQ[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cycleCnt = 0;
  int          benchC = 0;
  logic [15:0] lastRe = 16'h0;
  logic [15:0] lastIm = 16'h0;
  logic [15:0] pendTwRe = 16'h0;
  logic [15:0] pendTwIm = 16'h0;

  always #5 clock = ~clock;

  twiddle_rotator #(
    .WIDTH(16),
    .LOG_N(6),
    .LOG_M(6)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .di_en  (di_en),
    .di_re  (di_re),
    .di_im  (di_im),
    .tw_addr(tw_addr),
    .tw_re  (tw_re),
    .tw_im  (tw_im),
    .do_en  (do_en),
    .do_re  (do_re),
    .do_im  (do_im)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  function automatic logic [7:0] expAddr(input int c);
    int s, i, k;
    s = (c >> 4) & 3;
    i = c & 15;
    k = (s == 1) ? 2 : (s == 2) ? 1 : s;
    return 8'(i * k);
  endfunction

  function automatic logic [15:0] clamp16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [31:0] refRotate(input logic [15:0] dr, input logic [15:0] dim,
                                            input logic [15:0] tr, input logic [15:0] ti);
    longint a, b, c, d, re, im;
    a = $signed(dr);
    b = $signed(dim);
    c = $signed(tr);
    d = $signed(ti);
    re = (a * c - b * d + 16384) >>> 15;
    im = (a * d + b * c + 16384) >>> 15;
    return {clamp16(re), clamp16(im)};
  endfunction

  // Twiddle for a sample is presented one cycle after the sample, like the registered ROM.
  task automatic applyStimulus(input logic en, input logic [15:0] re, input logic [15:0] im,
                               input logic [15:0] twr, input logic [15:0] twi,
                               input logic [15:0] expRe, input logic [15:0] expIm,
                               input logic [7:0] addrReq);
    @(negedge clock);
    di_en = en;
    di_re = re;
    di_im = im;
    tw_re = pendTwRe;
    tw_im = pendTwIm;
    pendTwRe = twr;
    pendTwIm = twi;
    #1;
    checkOutput($sformatf("tw_addr c=%0d", benchC), {24'h0, tw_addr}, {24'h0, addrReq});
    if (en) begin
      sbQ.push_back('{re: expRe, im: expIm, cyc: cycleCnt});
      benchC = (benchC + 1) % 64;
    end
  endtask

  task automatic sendModel(input logic [15:0] re, input logic [15:0] im,
                           input logic [15:0] twr, input logic [15:0] twi);
    logic [7:0]  a;
    logic [31:0] r;
    a = expAddr(benchC);
    r = (a == 8'd0) ? {re, im} : refRotate(re, im, twr, twi);
    applyStimulus(1'b1, re, im, twr, twi, r[31:16], r[15:0], a);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 16'($urandom), 16'($urandom), 16'h0, 16'h0, 16'h0, 16'h0, expAddr(benchC));
  endtask

  // Monitor: samples one time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      cycleCnt++;
      #1;
      if (do_en === 1'b1) begin
        if (sbQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected do_en: got do=(%h,%h), required no output", do_re, do_im);
        end else begin
          e = sbQ.pop_front();
          checkOutput("do_re", {16'h0, do_re}, {16'h0, e.re});
          checkOutput("do_im", {16'h0, do_im}, {16'h0, e.im});
          checkOutput("latency", 32'(cycleCnt - e.cyc), 32'd3);
          lastRe = e.re;
          lastIm = e.im;
        end
      end else begin
        checkOutput("hold do_re", {16'h0, do_re}, {16'h0, lastRe});
        checkOutput("hold do_im", {16'h0, do_im}, {16'h0, lastIm});
      end
    end
  end

  initial begin
    int hc[9];
    int ha[9];
    logic [7:0]  a;
    logic [15:0] dr, dim, twr, twi;
    int n;
    hc = '{0, 15, 17, 31, 33, 47, 49, 63, 64};
    ha = '{0, 0, 2, 30, 1, 15, 3, 45, 0};

    reset = 1'b1;
    di_en = 1'b0;
    di_re = 16'h0;
    di_im = 16'h0;
    tw_re = 16'h0;
    tw_im = 16'h0;

    // Reset held two cycles with live random inputs.
    for (int r = 0; r < 2; r++) begin
      @(negedge clock);
      di_en = 1'b1;
      di_re = 16'($urandom);
      di_im = 16'($urandom);
      tw_re = 16'($urandom);
      tw_im = 16'($urandom);
      #1;
      checkOutput("reset do_en", {31'h0, do_en}, 32'd0);
      checkOutput("reset do_re", {16'h0, do_re}, 32'h0);
      checkOutput("reset do_im", {16'h0, do_im}, 32'h0);
      checkOutput("reset tw_addr", {24'h0, tw_addr}, 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    di_en = 1'b0;
    for (int r = 0; r < 4; r++) begin
      idleCycle();
      checkOutput("idle do_en", {31'h0, do_en}, 32'd0);
    end

    // One full block back to back plus the wrap sample, with the directed vectors embedded.
    for (int c = 0; c <= 64; c++) begin
      a = expAddr(c % 64);
      for (int h = 0; h < 9; h++) begin
        if (hc[h] == c) a = 8'(ha[h]);
      end
      if (c == 5) begin
        applyStimulus(1'b1, 16'h1234, 16'hEDCC, 16'h7FFF, 16'h7FFF, 16'h1234, 16'hEDCC, a);
      end else if (c == 17) begin
        applyStimulus(1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0001, a);
      end else if (c == 40) begin
        applyStimulus(1'b1, 16'h4000, 16'h0000, 16'h5A82, 16'hA57E, 16'h2D41, 16'hD2BF, 8'd8);
      end else begin
        dr  = 16'((c * 2731) ^ 32'h5A5A);
        dim = 16'(32'h8000 + c * 911);
        twr = (c % 64 < 16) ? 16'($urandom) : ((c % 2 == 0) ? 16'h5A82 : 16'h7FFF);
        twi = (c % 64 < 16) ? 16'($urandom) : ((c % 2 == 0) ? 16'hA57E : 16'h0000);
        a   = (a == expAddr(c % 64)) ? a : 8'hFF;
        applyStimulus(1'b1, dr, dim, twr, twi,
                      (expAddr(c % 64) == 0) ? dr  : refRotate(dr, dim, twr, twi) >> 16,
                      (expAddr(c % 64) == 0) ? dim : 16'(refRotate(dr, dim, twr, twi)), a);
      end
    end
    for (int r = 0; r < 5; r++) idleCycle();

    // Advance to c=33, then samples every other cycle: address only moves on valid cycles.
    while (benchC != 33) sendModel(16'(benchC * 300), 16'(-benchC * 170), 16'h30FC, 16'h89BE);
    for (int g = 0; g < 8; g++) begin
      sendModel(16'(g * 4000 + 123), 16'(16'h9000 + g * 777), 16'h7642, 16'hCF04);
      idleCycle();
    end
    for (int r = 0; r < 5; r++) idleCycle();

    @(negedge clock);
    reset = 1'b1;
    di_en = 1'b0;
    benchC = 0;
    lastRe = 16'h0;
    lastIm = 16'h0;
    @(negedge clock);
    reset = 1'b0;

    // Back to back up to c=19, then reset lands on c=20 while samples are still in the pipe.
    while (benchC != 20) sendModel(16'(benchC * 1500 + 7), 16'(benchC * 2100 - 9000), 16'h5A82, 16'hA57E);
    @(negedge clock);
    reset = 1'b1;
    di_en = 1'b1;
    di_re = 16'h5555;
    di_im = 16'hAAAA;
    #1;
    checkOutput("tw_addr c=20", {24'h0, tw_addr}, 32'd8);
    sbQ.delete();
    lastRe = 16'h0;
    lastIm = 16'h0;
    benchC = 0;
    pendTwRe = 16'h0;
    pendTwIm = 16'h0;
    @(negedge clock);
    reset = 1'b0;
    di_en = 1'b0;
    applyStimulus(1'b1, 16'h7777, 16'h1111, 16'h5A82, 16'hA57E, 16'h7777, 16'h1111, 8'd0);
    for (int r = 0; r < 4; r++) idleCycle();

    n = 0;
    while (sbQ.size() > 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    compared++;
    if (sbQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d outputs pending, required 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/twiddle_rotator.md
# twiddle_rotator

Twiddle-multiply stage of the radix-2^2 single-path delay-feedback FFT. It consumes the streaming output of a butterfly pair and counts samples within each M-sample block. It derives the twiddle index for each sample and drives it to the twiddle ROM, which has a registered output (one-cycle read). It then applies a Q1.15 complex rotation to the delayed sample and emits the result to the next butterfly stage, bypassing the multiplier on index 0.

## Interface
- WIDTH, 16, data and twiddle word width (signed, twiddle Q1.15)
- LOG_N, 6, log2 of FFT size N (twiddle ROM holds N entries)
- LOG_M, 6, log2 of block size M handled by this stage; LOG_M ≤ LOG_N, LOG_M ≥ 3
- clock  in  1  master clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- di_en  in  1  input sample valid
- di_re, di_im  in  WIDTH each  input sample
- tw_addr  out  8  twiddle ROM address, combinational from the sample counter
- tw_re, tw_im  in  WIDTH each  twiddle value, valid one cycle after tw_addr
- do_en  out  1  output sample valid
- do_re, do_im  out  WIDTH each  rotated sample

## Operation
- Counter c is LOG_M bits. It increments on each cycle with di_en=1 and wraps from M-1 to 0. It holds while di_en=0. Gaps of any length are allowed.
- sel = c[LOG_M-1:LOG_M-2] and idx = c[LOG_M-3:0]. The multiplier k maps sel 0→0, 1→2, 2→1, 3→3.
- tw_addr = (idx*k) << (LOG_N-LOG_M), zero-extended to 8 bits. It is driven every cycle from the current c, whether or not di_en is asserted.
- Bypass flag b = (tw_addr==0), captured with the sample. When b=1 the sample passes unchanged.
- Rotation, when b=0:
  - re = di_re*tw_re − di_im*tw_im
  - im = di_re*tw_im + di_im*tw_re
  - Products are full 2·WIDTH signed. Sums are 2·WIDTH+1 bits.
- Rounding: add 2^(WIDTH-2), then arithmetic shift right by WIDTH-1.
- Saturation: clamp to [−2^(WIDTH-1), 2^(WIDTH-1)−1], i.e. [0x8000, 0x7FFF] for WIDTH=16.

## Timing
- Latency is 3 cycles, di_en→do_en, fixed for both bypass and multiply samples. Throughput is 1 sample/cycle.
- Pipeline registers:
  - P1 (t+1): data, b and valid registered; tw_re/tw_im valid in this cycle.
  - P2 (t+2): four products, b, delayed data, valid.
  - P3 (t+3): sums, round/saturate or bypass select, then the output register.
- Outputs change only on do_en cycles. do_re/do_im hold their last value while do_en=0.
- Reset state:
  - c=0, all valid bits 0.
  - do_en=0, do_re=do_im=0.
  - tw_addr=0, since it follows c.
- Reset mid-frame: in-flight samples are discarded, so no do_en for them. The first valid sample after reset gets c=0. A di_en that coincides with reset is ignored.
- Wrap: the sample at c=M-1 uses sel=3, idx=2^(LOG_M-2)−1. The next valid sample gets c=0 with no bubble.

## Structure
- Shared package fft_pkg holds:
  - WIDTH, LOG_N default constants.
  - Rounding constant and saturation bounds.
  - The sel→k mapping function.
- One natural sub-module: cmult_q15. It is a two-stage pipelined complex multiplier with rounding and saturation, covering P2–P3. Counter, address generation, bypass and P1 live in twiddle_rotator.

## Test plan
- Reset: hold reset for 2 cycles while driving random inputs. Required: do_en=0, do_re=do_im=0x0000, tw_addr=0. After release with no input, do_en stays 0.
- Address sequence: 64 back-to-back valid samples, LOG_N=LOG_M=6. Required tw_addr values:
  - c=0..15 → 0
  - c=17 → 2, c=31 → 30
  - c=33 → 1, c=47 → 15
  - c=49 → 3, c=63 → 45
  - next c=0 → 0
- Bypass: at c=5, di=(0x1234, 0xEDCC). Required: do=(0x1234, 0xEDCC) exactly 3 cycles later, do_en=1 for one cycle.
- Rotation: at c=40 (tw_addr=8), bench returns tw=(0x5A82, 0xA57E) next cycle, di=(0x4000, 0x0000). Required: do=(0x2D41, 0xD2BF) at t+3.
- Saturation and rounding: at non-bypass c=17, di=(0x8000, 0x8000), tw=(0x8000, 0x7FFF). Required: do_re=0x7FFF (saturated), do_im=0x0001 (rounded).
- Gaps and reset mid-frame:
  - di_en every other cycle: c advances only on valid cycles, and do_en follows each input exactly 3 cycles later.
  - Assert reset at c=20 with 3 samples in flight: none of them emerge, and the next valid sample gets c=0 with tw_addr=0.
